// File: rtl/nib_mbox_pkg.sv
// Shared register map, bit positions and STATUS layout for the NIB inter-core mailbox.
// Offsets are the word index taken from addr_i[4:2].
package nib_mbox_pkg;

  localparam logic [2:0] MBOX_DATA   = 3'd0;
  localparam logic [2:0] MBOX_STATUS = 3'd1;
  localparam logic [2:0] MBOX_CTRL   = 3'd2;
  localparam logic [2:0] MBOX_THRESH = 3'd3;
  localparam logic [2:0] MBOX_PEEK   = 3'd4;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_UDF   = 19;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_ERR = 2;

  typedef struct packed {
    logic [11:0] rsvd;
    logic        udf;
    logic        ovf;
    logic        full;
    logic        empty;
    logic [15:0] count;
  } mbox_status_t;

endpackage

// File: rtl/mbox_fifo.sv
// Mailbox word storage: circular buffer with separate count; push when full / pop when empty are ignored.
// Head is combinational from rd_ptr; pointer/count updates land on the next clk edge. No backpressure.
module mbox_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   head_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_next_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_d + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_d - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/nib_mailbox_slave.sv
// NIB slave mailbox: DATA/STATUS/CTRL/THRESH/PEEK decode, sticky errors, registered doorbell irq_o.
// Reads are combinational same-cycle; irq_o lags the access by one clk. THRESH exists only with NIB_MBOX_WATERMARK_EN.
module nib_mailbox_slave
  import nib_mbox_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rd_data_o,
  output logic        irq_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]   off;
  logic         wr, rd, push, pop, ctrl_wr, flush, clr_err;
  logic [31:0]  head;
  logic [AW:0]  count, count_next;
  logic         ovf_q, ovf_d, udf_q, udf_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [15:0]  count_next16;
  mbox_status_t status;
  logic         unused_addr;

  // Upper address bits are decoded by the NIB; only the word index matters here.
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0], BASE_ADDR};

  assign off     = addr_i[4:2];
  assign wr      = req_i & we_i;
  assign rd      = req_i & ~we_i;
  assign push    = wr & (off == MBOX_DATA);
  assign pop     = rd & (off == MBOX_DATA);
  assign ctrl_wr = wr & (off == MBOX_CTRL);
  assign flush   = ctrl_wr & wdata_i[CTRL_FLUSH];
  assign clr_err = ctrl_wr & wdata_i[CTRL_CLR_ERR];

  mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (flush),
    .wdata_i      (wdata_i),
    .head_o       (head),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (full_o),
    .empty_o      (empty_o)
  );

  assign count_next16 = 16'(count_next);

`ifdef NIB_MBOX_WATERMARK_EN
  logic [15:0] thresh_q, thresh_d, thresh_eff;
  assign thresh_d   = (wr && off == MBOX_THRESH) ? wdata_i[15:0] : thresh_q;
  assign thresh_eff = (thresh_q == '0) ? 16'd1 : thresh_q;
  always_ff @(posedge clk) begin
    if (rst) thresh_q <= '0;
    else     thresh_q <= thresh_d;
  end
`endif

  always_comb begin
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    irq_en_d = irq_en_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push && full_o)  ovf_d = 1'b1;
    if (pop && empty_o)  udf_d = 1'b1;
    if (ctrl_wr)         irq_en_d = wdata_i[CTRL_IRQ_EN];
`ifdef NIB_MBOX_WATERMARK_EN
    irq_d = irq_en_q & (count_next16 >= thresh_eff) & (count_next16 != '0);
`else
    irq_d = irq_en_q & (count_next16 != '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o  = irq_q;
  assign status = '{rsvd: '0, udf: udf_q, ovf: ovf_q, full: full_o, empty: empty_o,
                    count: 16'(count)};

  always_comb begin
    rd_data_o = '0;
    if (rd) begin
      case (off)
        MBOX_DATA, MBOX_PEEK: rd_data_o = empty_o ? 32'h0 : head;
        MBOX_STATUS:          rd_data_o = status;
        MBOX_CTRL:            rd_data_o = {31'h0, irq_en_q};
`ifdef NIB_MBOX_WATERMARK_EN
        MBOX_THRESH:          rd_data_o = {16'h0, thresh_q};
`endif
        default:              rd_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nib_mailbox_slave.sv
// Randomized self-checking bench for nib_mailbox_slave against a queue-based mailbox model.
// Builds with or without NIB_MBOX_WATERMARK_EN.
module tb_nib_mailbox_slave;

  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic [31:0] rd_data;
  logic        irq, full, empty;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  bit          m_ovf, m_udf, m_en, m_irq;
  logic [15:0] m_thr;

  nib_mailbox_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .addr_i    (addr),
    .we_i      (we),
    .wdata_i   (wdata),
    .rd_data_o (rd_data),
    .irq_o     (irq),
    .full_o    (full),
    .empty_o   (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Mailbox behaviour as a queue; irq uses the enable/threshold in force before the access.
  task automatic mdl(input bit w, input logic [2:0] off, input logic [31:0] d,
                     output logic [31:0] exp);
    bit          en0;
    logic [15:0] thr0, cnt, eff;
    en0 = m_en;
    thr0 = m_thr;
    exp = 32'h0;
    case (off)
      3'd0: if (w) begin
              if (mq.size() < DEPTH) mq.push_back(d); else m_ovf = 1;
            end else begin
              if (mq.size() > 0) exp = mq.pop_front(); else m_udf = 1;
            end
      3'd1: if (!w) begin
              cnt = 16'(mq.size());
              exp = {12'h0, m_udf, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), cnt};
            end
      3'd2: if (w) begin
              m_en = d[0];
              if (d[1]) mq.delete();
              if (d[2]) begin m_ovf = 0; m_udf = 0; end
            end else exp = {31'h0, m_en};
`ifdef NIB_MBOX_WATERMARK_EN
      3'd3: if (w) m_thr = d[15:0]; else exp = {16'h0, m_thr};
`endif
      3'd4: if (!w && mq.size() > 0) exp = mq[0];
      default: exp = 32'h0;
    endcase
    cnt = 16'(mq.size());
`ifdef NIB_MBOX_WATERMARK_EN
    eff = (thr0 == 0) ? 16'd1 : thr0;
    m_irq = en0 && (cnt >= eff) && (cnt != 0);
`else
    eff = thr0;
    m_irq = en0 && (cnt != 0) && (eff == eff);
`endif
  endtask

  // One bus access: read data sampled mid-cycle, returns #1 after the active edge.
  task automatic acc(input bit w, input logic [2:0] off, input logic [31:0] d,
                     output logic [31:0] exp, output logic [31:0] got);
    mdl(w, off, d, exp);
    @(negedge clk);
    req = 1; we = w; addr = BASE + {27'h0, off, 2'b00}; wdata = d;
    #1 got = rd_data;
    @(posedge clk);
    #1 req = 0; we = 0; addr = 0; wdata = 0;
  endtask

  task automatic do_reset(input bit with_push);
    @(negedge clk);
    rst = 1;
    if (with_push) begin
      req = 1; we = 1; addr = BASE; wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1 rst = 0; req = 0; we = 0; addr = 0; wdata = 0;
    mq.delete();
    m_ovf = 0; m_udf = 0; m_en = 0; m_irq = 0; m_thr = 0;
  endtask

  task automatic test_reset();
    logic [31:0] e, g;
    rst = 0; req = 0; we = 0; addr = 0; wdata = 0;
    do_reset(0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++;
      $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g !== 32'h0001_0000) begin errors++; $display("FAIL reset_status got=%h exp=00010000", g); end
  endtask

  task automatic test_doorbell();
    logic [31:0] e, g;
    acc(1, 3'd2, 32'h1, e, g);
    acc(1, 3'd0, 32'hA5A5_0001, e, g);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL db_irq_set got=%b exp=1", irq); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g[15:0] !== 16'd1) begin errors++; $display("FAIL db_count got=%0d exp=1", g[15:0]); end
    acc(0, 3'd4, 0, e, g);
    checks++; if (g !== 32'hA5A5_0001) begin errors++; $display("FAIL db_peek got=%h exp=a5a50001", g); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g[15:0] !== 16'd1) begin errors++; $display("FAIL db_peek_nopop got=%0d exp=1", g[15:0]); end
    acc(0, 3'd0, 0, e, g);
    checks++; if (g !== 32'hA5A5_0001) begin errors++; $display("FAIL db_pop got=%h exp=a5a50001", g); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL db_irq_clr got=%b exp=0", irq); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g[15:0] !== 16'd0) begin errors++; $display("FAIL db_count0 got=%0d exp=0", g[15:0]); end
  endtask

  task automatic test_overflow_underflow();
    logic [31:0] e, g;
    for (int i = 0; i <= DEPTH; i++) acc(1, 3'd0, i, e, g);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g[ 18] !== 1'b1 || g[15:0] !== 16'(DEPTH)) begin errors++;
      $display("FAIL ovf_status got=%h exp ovf=1 count=%0d", g, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      acc(0, 3'd0, 0, e, g);
      checks++; if (g !== 32'(i)) begin errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, g, 32'(i)); end
    end
    acc(0, 3'd0, 0, e, g);
    checks++; if (g !== 32'h0) begin errors++; $display("FAIL udf_pop got=%h exp=0", g); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g[19:18] !== 2'b11) begin errors++; $display("FAIL udf_status got=%h exp udf=1 ovf=1", g); end
    acc(1, 3'd2, 32'h4, e, g);
    acc(0, 3'd1, 0, e, g);
    checks++; if (g !== 32'h0001_0000) begin errors++; $display("FAIL clr_err got=%h exp=00010000", g); end
  endtask

  task automatic test_wrap();
    logic [31:0] e, g;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) acc(1, 3'd0, $urandom, e, g);
      for (int i = 0; i < 10; i++) begin
        acc(0, 3'd0, 0, e, g);
        checks++; if (g !== e) begin errors++; $display("FAIL wrap_r%0d_%0d got=%h exp=%h", r, i, g, e); end
      end
    end
  endtask

`ifdef NIB_MBOX_WATERMARK_EN
  task automatic test_watermark();
    logic [31:0] e, g;
    acc(1, 3'd3, 32'd4, e, g);
    acc(1, 3'd2, 32'h1, e, g);
    for (int i = 0; i < 3; i++) begin
      acc(1, 3'd0, $urandom, e, g);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wm_below%0d got=%b exp=0", i, irq); end
    end
    acc(1, 3'd0, $urandom, e, g);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wm_reach got=%b exp=1", irq); end
    acc(1, 3'd2, 32'h2, e, g);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wm_flush_irq got=%b exp=0", irq); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g[15:0] !== 16'd0) begin errors++; $display("FAIL wm_flush_cnt got=%0d exp=0", g[15:0]); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] e, g, d;
    int          r;
    bit          w;
    logic [2:0]  off;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 13);
      d = $urandom;
      w = 0;
      if (r <= 4)       begin off = 3'd0; w = 1; end
      else if (r <= 7)  off = 3'd0;
      else if (r == 8)  off = 3'd1;
      else if (r == 9)  off = 3'd4;
      else if (r == 10) begin
        off = 3'd2; w = 1;
        d = {29'h0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), 1'($urandom)};
      end
      else if (r == 11) begin off = 3'd3; w = 1'($urandom); d = 32'($urandom_range(0, 8)) | (d & 32'hFFFF_0000); end
      else if (r == 12) begin off = 3'd2; w = 0; end
      else begin off = 3'($urandom_range(5, 7)); w = 1'($urandom); end
      acc(w, off, d, e, g);
      if (!w) begin
        checks++; if (g !== e) begin errors++; $display("FAIL rnd%0d_rd off=%0d got=%h exp=%h", n, off, g, e); end
      end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd%0d_irq got=%b exp=%b", n, irq, m_irq); end
      checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin errors++;
        $display("FAIL rnd%0d_flags got full=%b empty=%b exp count=%0d", n, full, empty, mq.size()); end
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] e, g;
    acc(1, 3'd2, 32'h1, e, g);
    for (int i = 0; i < 5; i++) acc(1, 3'd0, 32'h100 + i, e, g);
    do_reset(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b exp=0", irq); end
    acc(0, 3'd1, 0, e, g);
    checks++; if (g !== 32'h0001_0000) begin errors++; $display("FAIL mid_status got=%h exp=00010000", g); end
    acc(0, 3'd2, 0, e, g);
    checks++; if (g !== 32'h0) begin errors++; $display("FAIL mid_irq_en got=%h exp=0", g); end
    acc(0, 3'd0, 0, e, g);
    checks++; if (g !== 32'h0) begin errors++; $display("FAIL mid_pop got=%h exp=0", g); end
  endtask

  initial begin
    test_reset();
    test_doorbell();
    test_overflow_underflow();
    test_wrap();
`ifdef NIB_MBOX_WATERMARK_EN
    test_watermark();
`endif
    test_random();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
